// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single fixed-latency memory port.
// Optional fetch anti-starvation guard is enabled with macro ARB_FETCH_GUARD_EN.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [15:0] if_rdata,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StResp   = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic        owner_d_q;
  logic        we_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] if_rdata_q;
  logic [15:0] d_rdata_q;
  logic [2:0]  cnt_q;
  logic        arb_ok;
  logic        grant;
  logic        fetch_first;

  // Grants are only legal in IDLE/RESP and are suppressed while reset is held.
  assign arb_ok = rst_n && (state_q != StAccess);

`ifdef ARB_FETCH_GUARD_EN
  logic [3:0] starve_q;

  assign fetch_first = (starve_q == 4'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 4'd0;
    end else if (!if_req || if_gnt) begin
      starve_q <= 4'd0;
    end else if (d_gnt) begin
      starve_q <= starve_q + 4'd1;
    end
  end
`else
  assign fetch_first = 1'b0;
`endif

  always_comb begin
    d_gnt  = 1'b0;
    if_gnt = 1'b0;
    if (arb_ok) begin
      if (d_req && !(fetch_first && if_req)) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  assign grant = d_gnt | if_gnt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StResp: state_d = grant ? StAccess : StIdle;
      StAccess:       if (cnt_q == 3'd1) state_d = StResp;
      default:        state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_d_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      if_rdata_q <= 16'h0000;
      d_rdata_q  <= 16'h0000;
      cnt_q      <= 3'd0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_d_q <= d_gnt;
        addr_q    <= d_gnt ? d_addr : if_addr;
        we_q      <= d_gnt & d_we;
        wdata_q   <= d_gnt ? d_wdata : 16'h0000;
        cnt_q     <= 3'(MEM_LAT);
      end else if (state_q == StAccess) begin
        cnt_q <= cnt_q - 3'd1;
        // Last access cycle: capture read data into the owner's holding register only.
        if (cnt_q == 3'd1) begin
          if (owner_d_q) begin
            d_rdata_q <= we_q ? 16'h0000 : mem_rdata;
          end else begin
            if_rdata_q <= mem_rdata;
          end
        end
      end
    end
  end

  assign mem_en    = (state_q == StAccess);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_rvalid = (state_q == StResp) && !owner_d_q;
  assign d_rvalid  = (state_q == StResp) && owner_d_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_stall  = if_req & ~if_gnt;
  assign dbg_state = state_q;

endmodule
